turn_game_controller: RTL and testbench



---
 rtl/turn_game_controller.sv | 146 ++++++++++++++
 tb/tb_turn_game_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_game_controller.sv
// Turn-based game logic: rolls a die, advances the active player's square and
// hands the turn over (or declares a winner) once the animator reports done.
module turn_game_controller #(
   parameter int unsigned START_X        = 20,
   parameter int unsigned STEP_PX        = 20,
   parameter int unsigned FINISH_IDX     = 30,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       roll_btn,
   input  logic       dice_force_en,
   input  logic [2:0] dice_force_val,
   input  logic       turn_done,
   output logic [9:0] player1_pos_x,
   output logic [9:0] player2_pos_x,
   output logic       pos_valid,
   output logic       active_player,
   output logic [2:0] dice_value,
   output logic       busy,
   output logic       turn_timeout,
   output logic       winner_valid,
   output logic       winner
);
   localparam int unsigned X_W   = 10;
   localparam int unsigned IDX_W = 6;
   localparam int unsigned DIE_W = 3;
   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned MAX_X = START_X + STEP_PX * FINISH_IDX;

   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] FINISH     = IDX_W'(FINISH_IDX);
   localparam logic [X_W-1:0]   START_POS  = X_W'(START_X);
   localparam logic [X_W-1:0]   STEP_POS   = X_W'(STEP_PX);
   localparam logic [DIE_W-1:0] DIE_MAX    = DIE_W'(6);
   localparam logic [DIE_W-1:0] DIE_MIN    = DIE_W'(1);

   typedef enum logic [2:0] {IDLE, CALC, WAIT_DONE, CHECK, GAME_OVER} state_t;

   state_t           state_q, state_d;
   logic             roll_prev_q;
   logic [DIE_W-1:0] die_q;
   logic [IDX_W-1:0] idx1_q, idx2_q;
   logic [TO_W-1:0]  to_cnt_q;

   logic             roll_pulse_c, to_expire_c, at_finish_c, busy_d_c;
   logic             load_roll_c, calc_c, timeout_c, check_c;
   logic [IDX_W-1:0] act_idx_c, sum_c, new_idx_c;
   logic [X_W-1:0]   new_x_c;

   assign roll_pulse_c = roll_btn & ~roll_prev_q;
   assign to_expire_c  = (to_cnt_q == TO_LAST);
   assign act_idx_c    = active_player ? idx2_q : idx1_q;
   assign at_finish_c  = (act_idx_c == FINISH);
   assign sum_c        = act_idx_c + IDX_W'(dice_value);
   assign new_idx_c    = (sum_c > FINISH) ? FINISH : sum_c;
   assign new_x_c      = START_POS + X_W'(new_idx_c) * STEP_POS;
   assign busy_d_c     = (state_d == CALC) || (state_d == WAIT_DONE) || (state_d == CHECK);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; turn_done takes priority over a coincident timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (roll_pulse_c) state_d = CALC;
         CALC:      state_d = WAIT_DONE;
         WAIT_DONE: if (turn_done || to_expire_c) state_d = CHECK;
         CHECK:     state_d = at_finish_c ? GAME_OVER : IDLE;
         GAME_OVER: state_d = GAME_OVER;
         default:   state_d = IDLE;
      endcase
   end

   // Per-state datapath strobes
   always_comb begin
      load_roll_c = 1'b0;
      calc_c      = 1'b0;
      timeout_c   = 1'b0;
      check_c     = 1'b0;
      case (state_q)
         IDLE:      load_roll_c = roll_pulse_c;
         CALC:      calc_c      = 1'b1;
         WAIT_DONE: timeout_c   = ~turn_done & to_expire_c;
         CHECK:     check_c     = 1'b1;
         default:   ;
      endcase
   end

   // Registered datapath; turn_timeout lands in the CHECK cycle after expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         roll_prev_q   <= 1'b0;
         die_q         <= DIE_MIN;
         idx1_q        <= '0;
         idx2_q        <= '0;
         to_cnt_q      <= '0;
         player1_pos_x <= START_POS;
         player2_pos_x <= START_POS;
         pos_valid     <= 1'b0;
         active_player <= 1'b0;
         dice_value    <= '0;
         busy          <= 1'b0;
         turn_timeout  <= 1'b0;
         winner_valid  <= 1'b0;
         winner        <= 1'b0;
      end else begin
         roll_prev_q  <= roll_btn;
         die_q        <= (die_q == DIE_MAX) ? DIE_MIN : die_q + DIE_W'(1);
         pos_valid    <= calc_c;
         turn_timeout <= timeout_c;
         busy         <= busy_d_c;
         if (load_roll_c)
            dice_value <= dice_force_en ? dice_force_val : die_q;
         if (calc_c) begin
            to_cnt_q <= '0;
            if (active_player) begin
               idx2_q        <= new_idx_c;
               player2_pos_x <= new_x_c;
            end else begin
               idx1_q        <= new_idx_c;
               player1_pos_x <= new_x_c;
            end
         end else if (state_q == WAIT_DONE) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
         end
         if (check_c) begin
            if (at_finish_c) begin
               winner       <= active_player;
               winner_valid <= 1'b1;
            end else begin
               active_player <= ~active_player;
            end
         end
      end
   end

   // The flag x coordinate must fit the 10-bit position outputs
   always @(posedge clk) begin
      if (!rst) assert (MAX_X <= 32'd1023) else $error("finish x %0d exceeds 10 bits", MAX_X);
   end
endmodule

// File: tb/tb_turn_game_controller.sv
// Self-checking bench for turn_game_controller: directed scenarios plus a
// randomized full game checked against a square-index game model.
module tb_turn_game_controller;
   localparam int unsigned START_X        = 20;
   localparam int unsigned STEP_PX        = 20;
   localparam int unsigned FINISH_IDX     = 30;
   localparam int unsigned TIMEOUT_CYCLES = 1000;

   logic       clk = 1'b0;
   logic       rst, roll_btn, dice_force_en, turn_done;
   logic [2:0] dice_force_val;
   logic [9:0] player1_pos_x, player2_pos_x;
   logic       pos_valid, active_player, busy, turn_timeout, winner_valid, winner;
   logic [2:0] dice_value;

   int n_cmp = 0;
   int n_err = 0;
   int edge_cnt;
   int m_idx[2];
   int m_active;
   int pulses, pulse_at;
   logic [9:0] s_p1, s_p2;
   logic       s_act, s_busy;
   logic [2:0] s_dice;

   turn_game_controller #(
      .START_X(START_X), .STEP_PX(STEP_PX),
      .FINISH_IDX(FINISH_IDX), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .roll_btn(roll_btn), .dice_force_en(dice_force_en),
      .dice_force_val(dice_force_val), .turn_done(turn_done),
      .player1_pos_x(player1_pos_x), .player2_pos_x(player2_pos_x),
      .pos_valid(pos_valid), .active_player(active_player), .dice_value(dice_value),
      .busy(busy), .turn_timeout(turn_timeout), .winner_valid(winner_valid), .winner(winner)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release: the free-running die shows (edges mod 6)+1
   always @(posedge clk or posedge rst) begin
      if (rst) edge_cnt <= 0;
      else     edge_cnt <= edge_cnt + 1;
   end

   function automatic int exp_x(input int idx);
      return START_X + idx * STEP_PX;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_idx[0] = 0;
      m_idx[1] = 0;
      m_active = 0;
   endtask

   task automatic model_roll(input int d);
      m_idx[m_active] = (m_idx[m_active] + d > FINISH_IDX) ? FINISH_IDX : m_idx[m_active] + d;
   endtask

   task automatic do_reset();
      roll_btn = 0; dice_force_en = 0; dice_force_val = 0; turn_done = 0;
      rst = 1;
      tick();
      tick();
      rst = 0;
      model_reset();
      tick();
   endtask

   // Raise roll_btn for 'hold' edges and watch pos_valid for 'window' cycles
   task automatic start_roll(input bit fen, input logic [2:0] fval, input int hold, input int window);
      dice_force_en = fen; dice_force_val = fval; roll_btn = 1;
      pulses = 0; pulse_at = 0;
      for (int c = 1; c <= window; c++) begin
         tick();
         if (pos_valid) begin
            pulses++;
            if (pulses == 1) begin
               pulse_at = c; s_p1 = player1_pos_x; s_p2 = player2_pos_x;
               s_act = active_player; s_dice = dice_value; s_busy = busy;
            end
         end
         if (c == hold) roll_btn = 0;
      end
      roll_btn = 0;
   endtask

   task automatic end_with_done();
      turn_done = 1;
      tick();
      turn_done = 0;
   endtask

   task automatic play_forced(input logic [2:0] v);
      start_roll(1, v, 1, 4);
      model_roll(int'(v));
      end_with_done();
      tick();
      if (m_idx[m_active] != FINISH_IDX) m_active ^= 1;
      tick();
   endtask

   task automatic test_reset();
      roll_btn = 0; dice_force_en = 0; dice_force_val = 0; turn_done = 0;
      rst = 1;
      tick();
      n_cmp++;
      if ({player1_pos_x, player2_pos_x} !== {10'(START_X), 10'(START_X)}) begin
         n_err++; $display("FAIL reset_pos: got %0d/%0d expected %0d/%0d", player1_pos_x, player2_pos_x, START_X, START_X);
      end
      n_cmp++;
      if ({pos_valid, active_player, dice_value, busy, turn_timeout, winner_valid, winner} !== 9'b0) begin
         n_err++; $display("FAIL reset_flags: got %b expected 0", {pos_valid, active_player, dice_value, busy, turn_timeout, winner_valid, winner});
      end
      rst = 0;
      model_reset();
      pulses = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (pos_valid || busy) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_err++; $display("FAIL reset_quiet: got %0d active cycles expected 0", pulses);
      end
   endtask

   task automatic test_forced_roll();
      int extra;
      do_reset();
      start_roll(1, 3'd4, 10, 12);
      n_cmp++;
      if (pulses != 1 || pulse_at != 2) begin
         n_err++; $display("FAIL roll_pulse: got %0d pulses at %0d expected 1 at 2", pulses, pulse_at);
      end
      n_cmp++;
      if ({s_p1, s_p2, s_act, s_dice, s_busy} !== {10'd100, 10'd20, 1'b0, 3'd4, 1'b1}) begin
         n_err++; $display("FAIL roll_snapshot: got p1=%0d p2=%0d act=%0d dice=%0d busy=%0d expected 100 20 0 4 1", s_p1, s_p2, s_act, s_dice, s_busy);
      end
      extra = 0;
      for (int c = 0; c < 38; c++) begin
         tick();
         if (pos_valid) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_err++; $display("FAIL roll_held_once: got %0d extra pulses expected 0", extra);
      end
      end_with_done();
      tick();
      n_cmp++;
      if ({active_player, busy} !== 2'b10) begin
         n_err++; $display("FAIL turn_pass: got act=%0d busy=%0d expected act=1 busy=0", active_player, busy);
      end
   endtask

   task automatic test_win_clamp();
      logic [2:0] p1_rolls [5] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd4};
      logic [23:0] frozen;
      do_reset();
      for (int t = 0; t < 5; t++) begin
         play_forced(p1_rolls[t]);
         play_forced(3'd1);
      end
      n_cmp++;
      if (player1_pos_x !== 10'd580 || player2_pos_x !== 10'(exp_x(5))) begin
         n_err++; $display("FAIL win_setup: got p1=%0d p2=%0d expected 580 %0d", player1_pos_x, player2_pos_x, exp_x(5));
      end
      start_roll(1, 3'd5, 1, 4);
      n_cmp++;
      if (pulses != 1 || s_p1 !== 10'd620) begin
         n_err++; $display("FAIL win_clamp: got %0d pulses p1=%0d expected 1 620", pulses, s_p1);
      end
      end_with_done();
      tick();
      n_cmp++;
      if ({winner_valid, winner, busy} !== 3'b100) begin
         n_err++; $display("FAIL win_flag: got valid=%0d winner=%0d busy=%0d expected 1 0 0", winner_valid, winner, busy);
      end
      frozen = {player1_pos_x, player2_pos_x, active_player, dice_value};
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         roll_btn = (c % 6) < 2;
         turn_done = (c % 5) == 3;
         tick();
         if (pos_valid || busy || !winner_valid) pulses++;
      end
      roll_btn = 0; turn_done = 0;
      n_cmp++;
      if (pulses != 0 || frozen !== {10'd620, 10'(exp_x(5)), 1'b0, 3'd5}) begin
         n_err++; $display("FAIL game_over_frozen: got %0d bad cycles state=%h expected 0 %h", pulses, frozen, {10'd620, 10'(exp_x(5)), 1'b0, 3'd5});
      end
   endtask

   task automatic test_stray_inputs();
      int bad;
      do_reset();
      end_with_done();
      tick();
      n_cmp++;
      if ({busy, active_player, pos_valid} !== 3'b000) begin
         n_err++; $display("FAIL idle_turn_done: got busy=%0d act=%0d pv=%0d expected 0 0 0", busy, active_player, pos_valid);
      end
      dice_force_en = 1; dice_force_val = 3;
      roll_btn = 1;
      tick();
      roll_btn = 0; turn_done = 1;
      tick();
      pulses = pos_valid ? 1 : 0;
      turn_done = 0; roll_btn = 1;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         roll_btn = (c % 4) == 2;
         if (pos_valid) pulses++;
         if (!busy || active_player || player1_pos_x !== 10'd80 || player2_pos_x !== 10'd20) bad++;
      end
      roll_btn = 0;
      n_cmp++;
      if (pulses != 1) begin
         n_err++; $display("FAIL stray_pulses: got %0d pos_valid pulses expected 1", pulses);
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++; $display("FAIL stray_early_check: got %0d bad cycles expected 0", bad);
      end
      end_with_done();
      tick();
      n_cmp++;
      if (active_player !== 1'b1) begin
         n_err++; $display("FAIL stray_real_done: got act=%0d expected 1", active_player);
      end
   endtask

   task automatic test_timeout();
      int seen_at, to_cnt;
      do_reset();
      start_roll(1, 3'd2, 1, 3);
      seen_at = 0;
      for (int c = 4; c <= 1200 && seen_at == 0; c++) begin
         tick();
         if (turn_timeout) seen_at = c - 1;
      end
      n_cmp++;
      if (seen_at != TIMEOUT_CYCLES + 1 || busy !== 1'b1) begin
         n_err++; $display("FAIL timeout_pulse: got wait index %0d busy=%0d expected %0d 1", seen_at, busy, TIMEOUT_CYCLES + 1);
      end
      tick();
      n_cmp++;
      if ({turn_timeout, active_player, busy} !== 3'b010) begin
         n_err++; $display("FAIL timeout_pass: got to=%0d act=%0d busy=%0d expected 0 1 0", turn_timeout, active_player, busy);
      end
      tick();
      start_roll(1, 3'd6, 1, 4);
      n_cmp++;
      if (pulses != 1 || s_p2 !== 10'd140 || s_p1 !== 10'd60) begin
         n_err++; $display("FAIL timeout_next_roll: got %0d pulses p1=%0d p2=%0d expected 1 60 140", pulses, s_p1, s_p2);
      end
      to_cnt = 0;
      for (int c = 5; c <= TIMEOUT_CYCLES + 1; c++) begin
         tick();
         if (turn_timeout) to_cnt++;
      end
      end_with_done();
      if (turn_timeout) to_cnt++;
      n_cmp++;
      if (to_cnt != 0 || busy !== 1'b1) begin
         n_err++; $display("FAIL timeout_coincide: got %0d timeout pulses busy=%0d expected 0 1", to_cnt, busy);
      end
      tick();
      n_cmp++;
      if (active_player !== 1'b0) begin
         n_err++; $display("FAIL coincide_pass: got act=%0d expected 0", active_player);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      play_forced(3'd5);
      start_roll(1, 3'd3, 1, 5);
      #2 rst = 1;
      #1;
      n_cmp++;
      if ({player1_pos_x, player2_pos_x, active_player, busy, pos_valid, dice_value} !== {10'd20, 10'd20, 6'b0}) begin
         n_err++; $display("FAIL async_reset: got p1=%0d p2=%0d act=%0d busy=%0d dice=%0d expected 20 20 0 0 0", player1_pos_x, player2_pos_x, active_player, busy, dice_value);
      end
      tick();
      rst = 0;
      model_reset();
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (pos_valid) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_err++; $display("FAIL reset_release_pulse: got %0d expected 0", pulses);
      end
      start_roll(1, 3'd3, 1, 4);
      n_cmp++;
      if (pulses != 1 || {s_p1, s_p2, s_act} !== {10'd80, 10'd20, 1'b0}) begin
         n_err++; $display("FAIL post_reset_roll: got %0d pulses p1=%0d p2=%0d act=%0d expected 1 80 20 0", pulses, s_p1, s_p2, s_act);
      end
      end_with_done();
      tick();
   endtask

   task automatic test_random_game();
      bit over = 0;
      bit fen;
      logic [2:0] v;
      int d, a, seen;
      do_reset();
      for (int t = 0; t < 80 && !over; t++) begin
         fen = 1'($urandom % 2);
         v = 3'($urandom_range(1, 6));
         d = fen ? int'(v) : (edge_cnt % 6) + 1;
         start_roll(fen, v, $urandom_range(1, 4), 4);
         model_roll(d);
         n_cmp++;
         if (pulses != 1 || pulse_at != 2 || s_dice !== 3'(d)) begin
            n_err++; $display("FAIL rnd_roll t%0d: got %0d pulses at %0d dice=%0d expected 1 at 2 dice=%0d", t, pulses, pulse_at, s_dice, d);
         end
         n_cmp++;
         if ({s_p1, s_p2, s_act} !== {10'(exp_x(m_idx[0])), 10'(exp_x(m_idx[1])), 1'(m_active)}) begin
            n_err++; $display("FAIL rnd_pos t%0d: got p1=%0d p2=%0d act=%0d expected %0d %0d %0d", t, s_p1, s_p2, s_act, exp_x(m_idx[0]), exp_x(m_idx[1]), m_active);
         end
         if ($urandom % 10 == 0) begin
            seen = 0;
            for (int c = 0; c < 1100 && seen == 0; c++) begin
               tick();
               if (turn_timeout) seen = 1;
            end
            n_cmp++;
            if (seen != 1) begin
               n_err++; $display("FAIL rnd_timeout t%0d: got %0d expected 1", t, seen);
            end
         end else begin
            repeat ($urandom_range(0, 20)) tick();
            end_with_done();
         end
         tick();
         a = m_active;
         if (m_idx[a] == FINISH_IDX) over = 1;
         else m_active ^= 1;
         n_cmp++;
         if ({active_player, winner_valid, winner, busy} !== {1'(over ? a : m_active), over, over ? 1'(a) : 1'b0, 1'b0}) begin
            n_err++; $display("FAIL rnd_end t%0d: got act=%0d wv=%0d w=%0d busy=%0d expected act=%0d wv=%0d", t, active_player, winner_valid, winner, busy, over ? a : m_active, over);
         end
         tick();
         tick();
      end
      n_cmp++;
      if (!over) begin
         n_err++; $display("FAIL rnd_game_end: got no winner expected a winner");
      end
   endtask

   initial begin
      test_reset();
      test_forced_roll();
      test_win_clamp();
      test_stray_inputs();
      test_timeout();
      test_reset_mid();
      test_random_game();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
